pin_event_rx: RTL and testbench
===============================

# pin_event_rx

Input-side companion to the LED/GPIO tristate driver. Samples the `D_IN_0` returns of up to `CHANNELS` SB_IO pins, synchronises and debounces each one, and turns every debounced level change into an event. Events are presented one at a time on a valid/ready interface to downstream logic such as counters or a host register file. Per-channel sticky overflow flags are kept for events lost while a channel's queue slot was occupied.

## Interface
- `CHANNELS`, 4: number of pin inputs, range 1–8.
- `DEBOUNCE_CYCLES`, 24000 (1 ms at 24 MHz): number of clock cycles a new level must hold before it is accepted; minimum 2.
- `clk`  in  1: system clock (12–48 MHz typical).
- `resetn`  in  1: asynchronous, active-low reset.
- `pin_in`  in  `CHANNELS`: raw `D_IN_0` from the SB_IO instances. Asynchronous to `clk`.
- `level`  out  `CHANNELS`: debounced pin levels.
- `evt_valid`  out  1: an event is presented.
- `evt_ready`  in  1: the consumer accepts the event.
- `evt_chan`  out  `$clog2(CHANNELS)` (min 1): channel index of the presented event.
- `evt_level`  out  1: new level of that channel (1 = rising edge, 0 = falling edge).
- `ovf`  out  `CHANNELS`: sticky overflow flag per channel.
- `ovf_clr`  in  `CHANNELS`: per-channel clear for `ovf`, single-cycle pulse.

## Operation
- **Synchroniser:** each channel has a two-flop chain `pin_in → sync1 → sync2`.
- **Debounce:** each channel keeps a counter `cnt` sized `$clog2(DEBOUNCE_CYCLES)` bits.
  - If `sync2 == level`: `cnt ← 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `level ← sync2`, `cnt ← 0`, and a change strobe fires.
  - Else: `cnt ← cnt+1`.
  - Any glitch back to the old level before the count completes resets `cnt`.
- **Pending slot:** one slot per channel, holding `pend` and `plev`.
  - A change strobe sets `pend=1` and `plev=new level`.
  - If `pend` was already 1 and is not being drained that cycle, the older event is overwritten, `plev` takes the newest level, and `ovf[i]` is set.
- **Output register:** holds `evt_valid`, `evt_chan` and `evt_level`.
  - It is loaded when it is empty, or when `evt_valid && evt_ready`.
  - Source is the lowest-index channel with `pend=1` (fixed priority); that channel's `pend` is cleared on the same edge.
  - If no channel is pending at load time, `evt_valid ← 0`.
- **Drain plus new strobe, same channel, same cycle:** `pend` stays 1 with the new level. No overflow is flagged.
- **Handshake stability:** while `evt_valid && !evt_ready`, `evt_chan` and `evt_level` hold stable.
- **Overflow flags:**
  - `ovf_clr[i]` clears `ovf[i]`.
  - If a set and a clear hit the same channel in the same cycle, set wins.
- **Reset:** all of the following are 0 — `sync1`, `sync2`, `cnt`, `level`, `pend`, `plev`, `evt_valid`, `evt_chan`, `evt_level`, `ovf`. A pin that is high when reset is released therefore produces one rising event after the debounce time.
- **Reset mid-operation:** clears in-flight counts and pending events with no output glitch. Outputs reach their reset values asynchronously.

## Timing
- **Pin change to `level`:** the new value is captured in `sync1` at edge 0 and is in `sync2` at edge 1. With the pin stable, `level` updates at edge `DEBOUNCE_CYCLES+1`.
- **`level` to event:** with the output register empty, `evt_valid` rises one edge later, at edge `DEBOUNCE_CYCLES+2`.
- **Throughput:** one event per cycle while `evt_ready` is held high. No bubble between consecutive pending events.
- **Glitch rejection:** a pulse on `sync2` shorter than `DEBOUNCE_CYCLES` cycles produces no `level` change and no event.
- **Recovery:** `resetn` deassertion is synchronised externally. The block runs from the first edge after release.

## Structure
- Package `pin_event_pkg`:
  - `CHAN_W` function (`$clog2` with minimum 1).
  - Default `DEBOUNCE_CYCLES` derived from `CLK_MHZ` (default 24).
  - Event struct `{chan, level}`.
- Sub-module `pin_debounce`:
  - One instance per channel via generate.
  - Contains the synchroniser, `cnt`, `level` and the change strobe.
  - Ports: `clk`, `resetn`, `pin`, `level`, `changed`.
- The top-level module contains the pending slots, the priority select, the output register and the overflow logic.

## Test plan
- **Clean edge:** `DEBOUNCE_CYCLES=4`, `evt_ready=1`; drive `pin_in[2]` 0→1 at cycle 10. Expect `level[2]=1` after edge 15 and a single event `chan=2`, `level=1` with `evt_valid` high after edge 16.
- **Glitch rejection:** pulse `pin_in[0]` high for 3 cycles, with `DEBOUNCE_CYCLES=4`. Expect no event and `level[0]` staying 0.
- **Priority and back-to-back:** with `evt_ready=0`, channels 3, 1 and 0 all change. Raise `evt_ready`; expect events in the order chan 0, 1, 3 on consecutive cycles, then `evt_valid=0`.
- **Overflow:** hold `evt_ready=0`; toggle `pin_in[1]` 0→1→0 with debounced spacing while a chan-0 event is stalled at the output. Expect `ovf[1]=1` and a later chan-1 event with `level=0`. Pulsing `ovf_clr[1]` then clears the flag; with set and clear in the same cycle, expect `ovf[1]` to stay 1.
- **Stall stability:** with `evt_valid=1` and `evt_ready=0` for 20 cycles, `evt_chan` and `evt_level` must not change.
- **Reset mid-debounce:** assert `resetn=0` during a count. All outputs must read 0 immediately. After release with the pin held high, exactly one rising event must follow.

Source files
------------

// File: rtl/pin_event_pkg.sv
// Shared definitions for the pin event receiver: channel-index width helper,
// default debounce length and the event record type.
package pin_event_pkg;

   // System clock in MHz; the default debounce window is 1 ms at this rate.
   localparam int CLK_MHZ             = 24;
   localparam int DEBOUNCE_CYCLES_DEF = CLK_MHZ * 1000;

   // Widest channel index supported (up to 8 channels).
   localparam int CHAN_W_MAX = 3;

   // One event as seen by a consumer: which channel and its new level.
   typedef struct packed {
      logic [CHAN_W_MAX-1:0] chan;
      logic                  level;
   } evt_t;

   // Channel-index width: $clog2 with a floor of one bit.
   function automatic int CHAN_W(input int n);
      if (n <= 1) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/pin_event_rx_if.sv
// Event stream interface: the receiver presents one event at a time with a
// valid/ready handshake.
interface pin_event_rx_if
   import pin_event_pkg::*;
#(
   parameter int CHANNELS = 4
);
   localparam int CW = CHAN_W(CHANNELS);

   logic          evt_valid;
   logic          evt_ready;
   logic [CW-1:0] evt_chan;
   logic          evt_level;

   modport master (
      output evt_valid,
      output evt_chan,
      output evt_level,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_chan,
      input  evt_level,
      output evt_ready
   );

endinterface

// File: rtl/pin_debounce.sv
// Single-channel input conditioner: two-flop synchroniser followed by a
// hold-time debouncer. 'changed' is high in the cycle whose clock edge
// updates 'level', so the caller can capture the event on that same edge.
module pin_debounce
   import pin_event_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic resetn,
   input  logic pin,
   output logic level,
   output logic changed
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic [CNT_W-1:0] r_cnt;
   logic             w_differs;
   logic             w_expire;

   // Synchronised input disagrees with the accepted level.
   assign w_differs = r_sync2 ^ r_level;
   // The disagreement has now lasted the full debounce window.
   assign w_expire  = w_differs & (r_cnt == CNT_LAST);

   // Two-flop synchroniser for the asynchronous pad input.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= pin;
         r_sync2 <= r_sync1;
      end
   end

   // Hold-time counter; any return to the old level restarts the window.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt   <= {CNT_W{1'b0}};
         r_level <= 1'b0;
      end else if (!w_differs) begin
         r_cnt   <= {CNT_W{1'b0}};
      end else if (w_expire) begin
         r_level <= r_sync2;
         r_cnt   <= {CNT_W{1'b0}};
      end else begin
         r_cnt   <= r_cnt + CNT_W'(1);
      end
   end

   assign level   = r_level;
   assign changed = w_expire;

endmodule

// File: rtl/pin_event_rx.sv
// Pin event receiver: debounces up to eight pad inputs and turns every
// accepted level change into an event on a valid/ready stream. Each channel
// has a one-deep pending slot; an event that is overwritten before it could
// be forwarded sets that channel's sticky overflow flag.
module pin_event_rx
   import pin_event_pkg::*;
#(
   parameter int CHANNELS        = 4,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [CHANNELS-1:0] pin_in,
   output logic [CHANNELS-1:0] level,
   pin_event_rx_if.master      evt_if,
   output logic [CHANNELS-1:0] ovf,
   input  logic [CHANNELS-1:0] ovf_clr
);

   localparam int CW = CHAN_W(CHANNELS);

   logic [CHANNELS-1:0] w_level;
   logic [CHANNELS-1:0] w_changed;
   logic [CHANNELS-1:0] w_drain;
   logic [CHANNELS-1:0] w_ovf_set;
   logic                w_any;
   logic [CW-1:0]       w_sel;
   logic                w_load;

   logic [CHANNELS-1:0] r_pend;
   logic [CHANNELS-1:0] r_plev;
   logic [CHANNELS-1:0] r_ovf;
   logic                r_valid;
   logic [CW-1:0]       r_chan;
   logic                r_evt_level;

   // One synchroniser/debouncer per pad.
   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      pin_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk     (clk),
         .resetn  (resetn),
         .pin     (pin_in[g]),
         .level   (w_level[g]),
         .changed (w_changed[g])
      );
   end

   // Output register accepts a new event when empty or when the current one
   // is being taken this cycle; this gives one event per cycle under ready.
   assign w_load = ~r_valid | evt_if.evt_ready;

   // Fixed-priority pick: the lowest-index pending channel wins.
   always_comb begin
      w_any = 1'b0;
      w_sel = {CW{1'b0}};
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (r_pend[i]) begin
            w_any = 1'b1;
            w_sel = CW'(i);
         end else begin
            w_any = w_any;
            w_sel = w_sel;
         end
      end
   end

   // Pending slot emptied by the output register load this cycle.
   always_comb begin
      w_drain = {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
         w_drain[i] = w_load & w_any & (w_sel == CW'(i));
      end
   end

   // A new strobe lands on a slot that is still occupied and not leaving:
   // the older event is lost.
   assign w_ovf_set = w_changed & r_pend & ~w_drain;

   // Pending slots; a strobe takes precedence over a drain so an event that
   // arrives while the previous one is forwarded stays pending.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pend <= {CHANNELS{1'b0}};
         r_plev <= {CHANNELS{1'b0}};
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (w_changed[i]) begin
               r_pend[i] <= 1'b1;
               r_plev[i] <= ~w_level[i];
            end else if (w_drain[i]) begin
               r_pend[i] <= 1'b0;
            end else begin
               r_pend[i] <= r_pend[i];
            end
         end
      end
   end

   // Output register; channel and level only move on a real load so they
   // stay stable while the consumer stalls.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_valid     <= 1'b0;
         r_chan      <= {CW{1'b0}};
         r_evt_level <= 1'b0;
      end else if (w_load) begin
         r_valid <= w_any;
         if (w_any) begin
            r_chan      <= w_sel;
            r_evt_level <= r_plev[w_sel];
         end else begin
            r_chan      <= r_chan;
            r_evt_level <= r_evt_level;
         end
      end else begin
         r_valid <= r_valid;
      end
   end

   // Sticky overflow flags; a simultaneous set beats the clear.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ovf <= {CHANNELS{1'b0}};
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (w_ovf_set[i]) begin
               r_ovf[i] <= 1'b1;
            end else if (ovf_clr[i]) begin
               r_ovf[i] <= 1'b0;
            end else begin
               r_ovf[i] <= r_ovf[i];
            end
         end
      end
   end

   assign level            = w_level;
   assign ovf              = r_ovf;
   assign evt_if.evt_valid = r_valid;
   assign evt_if.evt_chan  = r_chan;
   assign evt_if.evt_level = r_evt_level;

endmodule

// File: tb/tb_pin_event_rx.sv
// Bench for pin_event_rx: directed scenarios plus randomized pin activity.
// A reference model derives debounced levels from the pin history and pushes
// the expected level of every event into a per-channel queue; a monitor pops
// and compares on each handshake.
module tb_pin_event_rx;
   import pin_event_pkg::*;

   localparam int CH = 4;
   localparam int DB = 4;
   localparam int HL = DB + 2;

   logic          clk     = 1'b0;
   logic          resetn  = 1'b1;
   logic [CH-1:0] pin_in  = '0;
   logic [CH-1:0] ovf_clr = '0;
   logic [CH-1:0] level;
   logic [CH-1:0] ovf;

   pin_event_rx_if #(.CHANNELS(CH)) evt_if ();

   pin_event_rx #(
      .CHANNELS        (CH),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clk     (clk),
      .resetn  (resetn),
      .pin_in  (pin_in),
      .level   (level),
      .evt_if  (evt_if),
      .ovf     (ovf),
      .ovf_clr (ovf_clr)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int n_evt   = 0;
   bit chk_ovf = 1'b1;

   // Reference model state: pin values seen before each of the last HL edges.
   logic [CH-1:0] hist [HL];
   logic [CH-1:0] mlevel = '0;
   bit            exp_q [CH][$];
   int            hold [CH];
   int            glitch [CH];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int j = 0; j < HL; j++) hist[j] = '0;
      mlevel = '0;
      for (int i = 0; i < CH; i++) exp_q[i].delete();
   endtask

   // A level is accepted once the synchronised pin (pin delayed by two edges)
   // has disagreed with it for DB consecutive edges.
   task automatic model_step();
      bit stable;
      if (!resetn) begin
         model_reset();
         return;
      end
      for (int j = HL - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = pin_in;
      for (int i = 0; i < CH; i++) begin
         stable = 1'b1;
         for (int j = 2; j < HL; j++) begin
            if (hist[j][i] == mlevel[i]) stable = 1'b0;
         end
         if (stable) begin
            mlevel[i] = ~mlevel[i];
            exp_q[i].push_back(mlevel[i]);
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Monitor: level and idle overflow every cycle; events on each handshake.
   initial forever begin
      evt_t obs;
      @(negedge clk);
      check("level", 32'(level), 32'(mlevel));
      if (chk_ovf) check("ovf_idle", 32'(ovf), 32'd0);
      if (evt_if.evt_valid && evt_if.evt_ready) begin
         obs.chan  = 3'(evt_if.evt_chan);
         obs.level = evt_if.evt_level;
         n_evt++;
         if (exp_q[obs.chan].size() == 0) begin
            n_total++;
            $display("FAIL evt_unexpected: got chan %0d level %0d, required no event", obs.chan, obs.level);
         end else begin
            check("evt_level", 32'(obs.level), 32'(exp_q[obs.chan].pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_cycles(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_level"}, 32'(level), 32'd0);
      check({tag, "_valid"}, 32'(evt_if.evt_valid), 32'd0);
      check({tag, "_chan"}, 32'(evt_if.evt_chan), 32'd0);
      check({tag, "_evtlev"}, 32'(evt_if.evt_level), 32'd0);
      check({tag, "_ovf"}, 32'(ovf), 32'd0);
   endtask

   task automatic random_phase(input int cycles, input int min_hold, input bit rand_ready);
      for (int i = 0; i < CH; i++) begin
         hold[i]   = 0;
         glitch[i] = 0;
      end
      for (int c = 0; c < cycles; c++) begin
         tick();
         if (rand_ready) evt_if.evt_ready = (c % 2 == 1) ? 1'b1 : 1'($urandom_range(0, 1));
         else evt_if.evt_ready = 1'b1;
         for (int i = 0; i < CH; i++) begin
            if (glitch[i] > 0) begin
               glitch[i]--;
               if (glitch[i] == 0) begin
                  pin_in[i] = ~pin_in[i];
                  hold[i]   = 0;
               end
            end else begin
               hold[i]++;
               if (hold[i] >= min_hold && $urandom_range(0, 7) == 0) begin
                  pin_in[i] = ~pin_in[i];
                  hold[i]   = 0;
                  if ($urandom_range(0, 2) == 0) glitch[i] = $urandom_range(1, DB - 1);
               end
            end
         end
      end
   endtask

   initial begin
      int n_evt0;
      int exp_chan [2];
      model_reset();
      evt_if.evt_ready = 1'b0;

      // Reset state.
      #1 resetn = 1'b0;
      #1 check_outputs_zero("reset");
      wait_cycles(2);
      resetn = 1'b1;

      // Clean rising edge on channel 2.
      evt_if.evt_ready = 1'b1;
      tick();
      pin_in[2] = 1'b1;
      for (int k = 0; k <= DB + 3; k++) begin
         tick();
         #1;
         if (k == DB) check("edge_level_early", 32'(level[2]), 32'd0);
         if (k == DB + 1) begin
            check("edge_level", 32'(level[2]), 32'd1);
            check("edge_valid_early", 32'(evt_if.evt_valid), 32'd0);
         end
         if (k == DB + 2) begin
            check("edge_valid", 32'(evt_if.evt_valid), 32'd1);
            check("edge_chan", 32'(evt_if.evt_chan), 32'd2);
            check("edge_evtlev", 32'(evt_if.evt_level), 32'd1);
         end
         if (k == DB + 3) check("edge_single", 32'(evt_if.evt_valid), 32'd0);
      end

      // Glitch of DB-1 cycles on channel 0 is rejected.
      pin_in[0] = 1'b1;
      wait_cycles(DB - 1);
      pin_in[0] = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         #1 check("glitch_valid", 32'(evt_if.evt_valid), 32'd0);
      end
      check("glitch_level", 32'(level[0]), 32'd0);

      // Priority, stall stability and back-to-back delivery.
      evt_if.evt_ready = 1'b0;
      pin_in[3] = 1'b1;
      pin_in[1] = 1'b1;
      pin_in[0] = 1'b1;
      wait_cycles(DB + 3);
      for (int k = 0; k < 20; k++) begin
         tick();
         #1;
         check("stall_valid", 32'(evt_if.evt_valid), 32'd1);
         check("stall_chan", 32'(evt_if.evt_chan), 32'd0);
         check("stall_evtlev", 32'(evt_if.evt_level), 32'd1);
      end
      evt_if.evt_ready = 1'b1;
      exp_chan[0] = 1;
      exp_chan[1] = 3;
      for (int k = 0; k < 2; k++) begin
         tick();
         #1;
         check("prio_valid", 32'(evt_if.evt_valid), 32'd1);
         check("prio_chan", 32'(evt_if.evt_chan), 32'(exp_chan[k]));
      end
      tick();
      #1 check("prio_empty", 32'(evt_if.evt_valid), 32'd0);

      // Overflow on channel 1 while a channel-0 event is stalled.
      pin_in[1] = 1'b0;
      wait_cycles(DB + 5);
      evt_if.evt_ready = 1'b0;
      pin_in[0] = 1'b0;
      wait_cycles(DB + 3);
      chk_ovf = 1'b0;
      pin_in[1] = 1'b1;
      wait_cycles(DB + 3);
      #1 check("ovf_not_yet", 32'(ovf[1]), 32'd0);
      pin_in[1] = 1'b0;
      wait_cycles(DB + 3);
      #1 check("ovf_set", 32'(ovf[1]), 32'd1);
      check("ovf_stalled_chan", 32'(evt_if.evt_chan), 32'd0);
      // The rising event was overwritten; only the newest level survives.
      exp_q[1].delete();
      exp_q[1].push_back(1'b0);
      evt_if.evt_ready = 1'b1;
      tick();
      #1;
      check("ovf_evt_chan", 32'(evt_if.evt_chan), 32'd1);
      check("ovf_evt_level", 32'(evt_if.evt_level), 32'd0);
      tick();
      #1;
      check("ovf_drained", 32'(evt_if.evt_valid), 32'd0);
      check("ovf_sticky", 32'(ovf), 32'd2);
      ovf_clr = 4'b0010;
      tick();
      ovf_clr = 4'b0000;
      #1 check("ovf_clear", 32'(ovf), 32'd0);

      // Set and clear on the same edge: set wins.
      evt_if.evt_ready = 1'b0;
      pin_in[3] = 1'b0;
      wait_cycles(DB + 3);
      pin_in[1] = 1'b1;
      wait_cycles(DB + 3);
      pin_in[1] = 1'b0;
      wait_cycles(DB + 1);
      ovf_clr = 4'b0010;
      tick();
      ovf_clr = 4'b0000;
      #1 check("ovf_set_wins", 32'(ovf[1]), 32'd1);
      exp_q[1].delete();
      exp_q[1].push_back(1'b0);
      evt_if.evt_ready = 1'b1;
      wait_cycles(DB);
      ovf_clr = 4'b0010;
      tick();
      ovf_clr = 4'b0000;
      #1 check("ovf_clear2", 32'(ovf), 32'd0);
      chk_ovf = 1'b1;

      // Reset in the middle of a debounce count.
      pin_in[2] = 1'b0;
      wait_cycles(DB + 5);
      pin_in[3] = 1'b1;
      wait_cycles(3);
      resetn = 1'b0;
      model_reset();
      #1 check_outputs_zero("midrst");
      wait_cycles(2);
      resetn = 1'b1;
      n_evt0 = n_evt;
      wait_cycles(DB + 8);
      check("midrst_one_event", 32'(n_evt - n_evt0), 32'd1);
      check("midrst_level", 32'(level), 32'h8);

      // Randomized activity: ready held high, then randomized ready.
      random_phase(400, 3 * DB, 1'b0);
      random_phase(600, 6 * DB, 1'b1);
      evt_if.evt_ready = 1'b1;
      wait_cycles(30);
      for (int i = 0; i < CH; i++) begin
         check("queue_empty", 32'(exp_q[i].size()), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
